acc_seq16: RTL and testbench
============================

ACC_SEQ16 -- requirements
Module: acc_seq16

Interface
REQ-001 Parameter BLK_LEN, default 4, number of 16-bit words summed per block (legal 2..255).
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 din  input  16  operand word from upstream.
REQ-005 din_vld  input  1  din valid.
REQ-006 din_rdy  output  1  block accepts din this cycle.
REQ-007 sum_out  output  16  registered block sum.
REQ-008 sum_vld  output  1  sum_out/ovf valid.
REQ-009 sum_rdy  input  1  downstream accepts sum.
REQ-010 ovf  output  1  sticky carry-out of the block (registered).
REQ-011 add_ain  output  16  operand A to external 16-bit combinational adder.
REQ-012 add_bin  output  16  operand B to external adder.
REQ-013 add_cin  output  1  carry-in to external adder.
REQ-014 add_sout  input  16  sum from external adder.
REQ-015 add_cout  input  1  carry-out from external adder.

Function
REQ-016 States: IDLE (no word of current block accepted), ACC (1..BLK_LEN-1 words accepted), OUT (result presented); 2-bit encoding.
REQ-017 Accept event = din_vld & din_rdy; din_rdy SHALL be 1 in IDLE and ACC, 0 in OUT.
REQ-018 Adder drive (combinational): add_ain = 0 in IDLE, acc register otherwise; add_bin = din; add_cin = 0 always.
REQ-019 On accept: acc <= add_sout; ovf_r <= ovf_r | add_cout; cnt <= cnt+1 (8-bit).
REQ-020 IDLE -> ACC on accept; ACC -> OUT on accept when cnt == BLK_LEN-1; otherwise hold state.
REQ-021 No accept (din_vld=0) SHALL leave acc, ovf_r, cnt, state unchanged; gaps allowed anywhere in a block.
REQ-022 In OUT: sum_vld=1, sum_out=acc, ovf=ovf_r, all held stable until sum_rdy=1.
REQ-023 OUT with sum_rdy=1 -> IDLE next cycle; acc, ovf_r, cnt cleared to 0; din_vld ignored during OUT (one-cycle bubble before next block).
REQ-024 Latency: sum_vld asserted the cycle after the BLK_LEN-th accept.
REQ-025 sum_out and ovf SHALL be 0 whenever sum_vld=0.
REQ-026 Arithmetic: modulo 2^16 wrap of acc; ovf set if any add in the block produced carry-out.

Reset
REQ-027 rst=1 at a clock edge SHALL force state IDLE, acc=0, ovf_r=0, cnt=0, regardless of state.
REQ-028 During/after reset: din_rdy=1, sum_vld=0, sum_out=0, ovf=0, add_ain=0.
REQ-029 Reset mid-block discards all accepted words; next block starts fresh; rst has priority over accept and sum_rdy in the same cycle.

Configuration
REQ-030 Macro ACC_SAT_EN: when defined, on accept with add_cout=1 or ovf_r=1, acc <= 16'hFFFF (saturate, sticky for rest of block); ovf behaviour unchanged.
REQ-031 Without ACC_SAT_EN, acc <= add_sout unconditionally (wrap per REQ-026).

Verification (BLK_LEN=4)
REQ-032 Words 0x0001,0x0002,0x0003,0x0004 back-to-back -> sum_vld 1 cycle after 4th accept, sum_out=0x000A, ovf=0.
REQ-033 Words 0xFFFF,0x0001,0x0000,0x0005 -> sum_out=0x0005, ovf=1; with ACC_SAT_EN sum_out=0xFFFF, ovf=1.
REQ-034 Block complete, sum_rdy held 0 for 5 cycles with din_vld=1 -> din_rdy=0, sum_out stable, no word accepted; sum_rdy=1 -> IDLE next cycle, din_rdy=1.
REQ-035 Words 0x0010,0x0020 accepted, rst pulsed 1 cycle, then 0x0001 x4 -> sum_out=0x0004, ovf=0.
REQ-036 Words 0x1000 x4 with din_vld low 2 cycles between each -> sum_out=0x4000, ovf=0, sum_vld exactly 1 cycle after last accept.

Source files
------------

// File: rtl/acc_seq16.sv
// acc_seq16: accumulates BLK_LEN words per block through an external adder; define ACC_SAT_EN to saturate instead of wrap.
module acc_seq16 #(
  parameter int BLK_LEN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] din,
  input  logic        din_vld,
  output logic        din_rdy,
  output logic [15:0] sum_out,
  output logic        sum_vld,
  input  logic        sum_rdy,
  output logic        ovf,
  output logic [15:0] add_ain,
  output logic [15:0] add_bin,
  output logic        add_cin,
  input  logic [15:0] add_sout,
  input  logic        add_cout
);
  typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, OUT = 2'd2} state_t;
  state_t state, state_nxt;
  logic [15:0] acc, acc_nxt;
  logic [7:0] cnt;
  logic ovf_r, accept, last;
  assign din_rdy = state != OUT;
  assign accept = din_vld & din_rdy;
  assign last = cnt == 8'(BLK_LEN - 1);
  assign add_ain = state == IDLE ? 16'h0000 : acc;
  assign add_bin = din;
  assign add_cin = 1'b0;
  assign sum_vld = state == OUT;
  assign sum_out = sum_vld ? acc : 16'h0000;
  assign ovf = sum_vld & ovf_r;
`ifdef ACC_SAT_EN
  assign acc_nxt = (add_cout | ovf_r) ? 16'hFFFF : add_sout;
`else
  assign acc_nxt = add_sout;
`endif
  always_comb begin
    state_nxt = state;
    if (state == IDLE && accept) state_nxt = ACC;
    else if (state == ACC && accept && last) state_nxt = OUT;
    else if (state == OUT && sum_rdy) state_nxt = IDLE;
  end
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : state_nxt;
  end
  always_ff @(posedge clk) begin
    if (rst || (state == OUT && sum_rdy)) begin
      acc <= '0;
      ovf_r <= 1'b0;
      cnt <= '0;
    end else if (accept) begin
      acc <= acc_nxt;
      ovf_r <= ovf_r | add_cout;
      cnt <= cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_acc_seq16.sv
// tb_acc_seq16: directed scoreboard bench for acc_seq16 with a behavioural external adder.
module tb_acc_seq16;
  logic clk = 0, rst = 1, din_vld = 0, sum_rdy = 0;
  logic [15:0] din = '0;
  logic din_rdy, sum_vld, ovf, add_cin, add_cout;
  logic [15:0] sum_out, add_ain, add_bin, add_sout;
  int n_chk = 0, n_err = 0;
  logic [16:0] sb [$];
  always #5 clk = ~clk;
  assign {add_cout, add_sout} = {1'b0, add_ain} + {1'b0, add_bin} + {16'h0000, add_cin};
  acc_seq16 #(.BLK_LEN(4)) dut (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .din_rdy(din_rdy),
    .sum_out(sum_out), .sum_vld(sum_vld), .sum_rdy(sum_rdy), .ovf(ovf),
    .add_ain(add_ain), .add_bin(add_bin), .add_cin(add_cin),
    .add_sout(add_sout), .add_cout(add_cout)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [16:0] model(input logic [15:0] w [4]);
    logic [15:0] a = '0;
    logic o = 0;
    logic [16:0] s;
    for (int i = 0; i < 4; i++) begin
      s = {1'b0, a} + {1'b0, w[i]};
      o = o | s[16];
`ifdef ACC_SAT_EN
      a = o ? 16'hFFFF : s[15:0];
`else
      a = s[15:0];
`endif
    end
    return {o, a};
  endfunction
  task automatic send(input logic [15:0] w, input int gap);
    int t = 0;
    din = w;
    din_vld = 1;
    while (din_rdy !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("rdy_wait", {31'd0, din_rdy}, 32'd1);
    @(negedge clk);
    din_vld = 0;
    repeat (gap) @(negedge clk);
  endtask
  task automatic block(input string tag, input logic [15:0] w [4], input int gap, input int hold);
    logic [16:0] e;
    sb.push_back(model(w));
    for (int i = 0; i < 4; i++) begin
      send(w[i], i == 3 ? 0 : gap);
      if (i == 0) chk({tag, "_ain"}, {16'd0, add_ain}, {16'd0, w[0]});
    end
    chk({tag, "_lat"}, {31'd0, sum_vld}, 32'd1);
    if (sum_vld === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_sum"}, {16'd0, sum_out}, {16'd0, e[15:0]});
      chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, e[16]});
      din = 16'hBEEF;
      din_vld = hold > 0;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk({tag, "_hold_rdy"}, {31'd0, din_rdy}, 32'd0);
        chk({tag, "_hold_sum"}, {16'd0, sum_out}, {16'd0, e[15:0]});
      end
    end
    sum_rdy = 1;
    @(negedge clk);
    sum_rdy = 0;
    din_vld = 0;
    chk({tag, "_idle_vld"}, {31'd0, sum_vld}, 32'd0);
    chk({tag, "_idle_rdy"}, {31'd0, din_rdy}, 32'd1);
    chk({tag, "_idle_sum"}, {15'd0, ovf, sum_out}, 32'd0);
    chk({tag, "_idle_ain"}, {16'd0, add_ain}, 32'd0);
  endtask
  initial begin
    logic [15:0] w [4];
    repeat (2) @(negedge clk);
    rst = 0;
    chk("rst_rdy", {31'd0, din_rdy}, 32'd1);
    chk("rst_vld", {31'd0, sum_vld}, 32'd0);
    chk("rst_out", {15'd0, ovf, sum_out}, 32'd0);
    chk("rst_ain", {16'd0, add_ain}, 32'd0);
    w = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    block("b1", w, 0, 0);
    w = '{16'hFFFF, 16'h0001, 16'h0000, 16'h0005};
    block("b2", w, 0, 5);
    w = '{16'h8000, 16'h8000, 16'h7FFF, 16'h0001};
    block("b3", w, 1, 0);
    send(16'h0010, 0);
    send(16'h0020, 0);
    chk("mid_ain", {16'd0, add_ain}, 32'h0030);
    rst = 1;
    din = 16'h0100;
    din_vld = 1;
    @(negedge clk);
    rst = 0;
    din_vld = 0;
    chk("mid_rst_ain", {16'd0, add_ain}, 32'd0);
    chk("mid_rst_rdy", {31'd0, din_rdy}, 32'd1);
    w = '{16'h0001, 16'h0001, 16'h0001, 16'h0001};
    block("b4", w, 0, 0);
    w = '{16'h1000, 16'h1000, 16'h1000, 16'h1000};
    block("b5", w, 2, 0);
    chk("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
